// File: rtl/radix2_calc_vj_pkg.sv
// radix2_calc_vj_pkg: signed-digit codes and helpers for the online multiplier
package radix2_calc_vj_pkg;
    localparam int RADIX_BITS = 2;
    localparam logic [RADIX_BITS-1:0] DIG_POS = 2'b01;
    localparam logic [RADIX_BITS-1:0] DIG_ZERO = 2'b00;
    localparam logic [RADIX_BITS-1:0] DIG_NEG = 2'b11;
    function automatic logic signed [1:0] dig_to_int(input logic [RADIX_BITS-1:0] d);
        return d == DIG_POS ? 2'sd1 : d == DIG_NEG ? -2'sd1 : 2'sd0;
    endfunction
    function automatic logic [RADIX_BITS-1:0] dig_neg(input logic [RADIX_BITS-1:0] d);
        return d == DIG_POS ? DIG_NEG : d == DIG_NEG ? DIG_POS : DIG_ZERO;
    endfunction
endpackage

// File: rtl/radix2_calc_vj_otf_converter.sv
// otf_converter: Q/QM on-the-fly conversion of a signed-digit stream to two's complement
module otf_converter
    import radix2_calc_vj_pkg::*;
#(
    parameter int N = 4,
    parameter int CW = 4
) (
    input logic clk,
    input logic reset,
    input logic clear,
    input logic [RADIX_BITS-1:0] digit,
    input logic [CW-1:0] k,
    output logic signed [N:0] q,
    output logic signed [N:0] q_next
);
    logic signed [N:0] qm, qm_next;
    logic [N:0] lsb;
    assign lsb = (k != '0 && k <= CW'(N)) ? (N+1)'(1) << (CW'(N) - k) : '0;
    always_comb begin
        q_next = digit == DIG_POS ? q | lsb : digit == DIG_NEG ? qm | lsb : q;
        qm_next = digit == DIG_POS ? q : digit == DIG_NEG ? qm : qm | lsb;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            q <= '0;
            qm <= {1'b1, {N{1'b0}}};
        end else if (clear) begin
            q <= '0;
            qm <= {1'b1, {N{1'b0}}};
        end else begin
            q <= q_next;
            qm <= qm_next;
        end
endmodule

// File: rtl/radix2_calc_vj.sv
// radix2_calc_vj: radix-2 online signed-digit multiplier datapath (V_j, selection, residual)
module radix2_calc_vj
    import radix2_calc_vj_pkg::*;
#(
    parameter int NO_OF_DIGITS = 4,
    parameter int DELTA = 3
) (
    input logic clk,
    input logic reset,
    input logic clear,
    input logic [RADIX_BITS-1:0] x,
    input logic [RADIX_BITS-1:0] y,
    input logic full_result_sel,
    output logic [RADIX_BITS-1:0] z,
    output logic [RADIX_BITS-1:0] neg_z,
    output logic z_valid
);
    localparam int N = NO_OF_DIGITS;
    localparam int F = N + DELTA;
    localparam int WW = F + 3;
    localparam int CW = $clog2(DELTA + 2 * N + 1);
    localparam logic signed [WW:0] ONE = {4'b0001, {F{1'b0}}};
    logic [CW-1:0] cnt, k;
    logic fsel, last, in_rng, pos, neg, conv_clear;
    logic [RADIX_BITS-1:0] xd, yd;
    logic signed [N:0] xq, xq_next, yq, yq_next;
    logic signed [WW-1:0] w;
    logic signed [WW:0] v, tx, ty, wn;
    logic signed [5:0] vh;
    assign k = cnt + CW'(1);
    assign in_rng = k <= CW'(N);
    assign xd = in_rng && x != 2'b10 ? x : DIG_ZERO;
    assign yd = in_rng && y != 2'b10 ? y : DIG_ZERO;
    assign last = cnt == (fsel ? CW'(DELTA + 2 * N - 1) : CW'(DELTA + N - 1));
    assign conv_clear = clear || last;
    otf_converter #(.N(N), .CW(CW)) u_x (
        .clk(clk), .reset(reset), .clear(conv_clear), .digit(xd), .k(k), .q(xq), .q_next(xq_next)
    );
    otf_converter #(.N(N), .CW(CW)) u_y (
        .clk(clk), .reset(reset), .clear(conv_clear), .digit(yd), .k(k), .q(yq), .q_next(yq_next)
    );
    always_comb begin
        tx = yd == DIG_POS ? (WW+1)'(xq) : yd == DIG_NEG ? -((WW+1)'(xq)) : '0;
        ty = xd == DIG_POS ? (WW+1)'(yq_next) : xd == DIG_NEG ? -((WW+1)'(yq_next)) : '0;
        v = $signed({w, 1'b0}) + tx + ty;
        vh = v[WW:F-2];
        z_valid = cnt >= CW'(DELTA);
        pos = z_valid && vh >= 6'sd2;
        neg = z_valid && vh < -6'sd2;
        z = pos ? DIG_POS : neg ? DIG_NEG : DIG_ZERO;
        neg_z = dig_neg(z);
        wn = pos ? v - ONE : neg ? v + ONE : v;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt <= '0;
            w <= '0;
            fsel <= 1'b0;
        end else if (conv_clear) begin
            cnt <= '0;
            w <= '0;
            fsel <= 1'b0;
        end else begin
            cnt <= k;
            w <= wn[WW-1:0];
            if (cnt == '0) fsel <= full_result_sel;
        end
endmodule

// File: tb/tb_radix2_calc_vj.sv
// tb_radix2_calc_vj: directed-vector check of the online multiplier digit stream
module tb_radix2_calc_vj;
    logic clk = 1'b0, reset = 1'b0, clear = 1'b0, full_result_sel = 1'b0;
    logic [1:0] x = 2'b00, y = 2'b00, z, neg_z;
    logic z_valid;
    int n_checks = 0, n_fail = 0;
    radix2_calc_vj dut (
        .clk(clk), .reset(reset), .clear(clear), .x(x), .y(y),
        .full_result_sel(full_result_sel), .z(z), .neg_z(neg_z), .z_valid(z_valid)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic run_op(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                          input logic fs, input logic [15:0] ez, input int abort_at,
                          input bit rst_abort, input bit chk_w);
        int len;
        logic [1:0] d, nd;
        len = fs ? 11 : 7;
        for (int c = 0; c < len; c++) begin
            x = c < 4 ? xv[7-2*c -: 2] : 2'b01;
            y = c < 4 ? yv[7-2*c -: 2] : 2'b11;
            full_result_sel = c == 0 ? fs : ~fs;
            if (c == abort_at) begin
                if (rst_abort) begin
                    #2 reset = 1'b0;
                    #1;
                    check($sformatf("%s_rst_z", tag), 32'(z), 32'(0));
                    check($sformatf("%s_rst_nz", tag), 32'(neg_z), 32'(0));
                    check($sformatf("%s_rst_v", tag), 32'(z_valid), 32'(0));
                    @(posedge clk);
                    #1 reset = 1'b1;
                end else begin
                    clear = 1'b1;
                    @(posedge clk);
                    #1 clear = 1'b0;
                end
                return;
            end
            @(negedge clk);
            check($sformatf("%s_c%0d_v", tag, c), 32'(z_valid), 32'(c >= 3));
            d = c >= 3 ? ez[15-2*(c-3) -: 2] : 2'b00;
            nd = d == 2'b01 ? 2'b11 : d == 2'b11 ? 2'b01 : 2'b00;
            check($sformatf("%s_c%0d_z", tag, c), 32'(z), 32'(d));
            check($sformatf("%s_c%0d_nz", tag, c), 32'(neg_z), 32'(nd));
            if (chk_w && c == 4) check($sformatf("%s_w4", tag), 32'(int'(dut.w)), 32'(-64));
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        #1;
        check("reset_z", 32'(z), 32'(0));
        check("reset_v", 32'(z_valid), 32'(0));
        @(posedge clk);
        #1 reset = 1'b1;
        run_op("zero", 8'hAA, 8'hAA, 1'b0, 16'h0000, -1, 0, 0);
        run_op("half_full", 8'h40, 8'h40, 1'b1, 16'h7000, -1, 0, 1);
        run_op("x15_n", 8'h55, 8'h40, 1'b0, 16'h4000, -1, 0, 0);
        run_op("x15_2n", 8'h55, 8'h40, 1'b1, 16'h40C0, -1, 0, 0);
        run_op("xneg", 8'hC0, 8'h40, 1'b0, 16'h3000, -1, 0, 0);
        run_op("b2b_a", 8'h40, 8'h40, 1'b0, 16'h7000, -1, 0, 0);
        run_op("b2b_b", 8'h55, 8'h40, 1'b0, 16'h4000, -1, 0, 0);
        run_op("clr_a", 8'h40, 8'h40, 1'b0, 16'h7000, 4, 0, 0);
        run_op("clr_b", 8'h55, 8'h40, 1'b0, 16'h4000, -1, 0, 0);
        run_op("rst_a", 8'h40, 8'h40, 1'b0, 16'h7000, 4, 1, 0);
        run_op("rst_b", 8'h55, 8'h40, 1'b0, 16'h4000, -1, 0, 0);
        x = 2'b00;
        y = 2'b00;
        @(negedge clk);
        check("idle_after_v", 32'(z_valid), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/radix2_calc_vj.md
# radix2_calc_vj

Radix-2 online (MSD-first) signed-digit multiplier datapath. Each cycle it accepts one digit of each operand and converts both operands on the fly to two's complement. It forms the online partial product V_j, selects one product digit and updates the scaled residual. It is the compute core of the online multiplier, fed directly by the digit-serial operand streams.

## Interface
- NO_OF_DIGITS, default 4: operand length n in digits; legal range 2..16.
- DELTA, default 3: online delay δ; must be ≥ 3.
- clk, in, 1: single clock, rising-edge active.
- reset, in, 1: reset is asynchronous and active-low.
- clear, in, 1: synchronous, active-high abort; returns the block to the idle state on the next edge.
- x, in, 2: operand digit x_i, i = 1..n.
- y, in, 2: operand digit y_i, i = 1..n.
- full_result_sel, in, 1: 0 selects an n-digit product; 1 selects a 2n-digit product.
- z, out, 2: product digit p.
- neg_z, out, 2: digit negation of z.
- z_valid, out, 1: z carries a product digit this cycle.

## Operation
- Digit encoding is 2-bit two's complement: 01 = +1, 00 = 0, 11 = −1. Code 10 is illegal and is treated as 0.
- Negation maps 01↔11 and 00→00.
- Value of an operand is Σ d_i·2^-i.
- State:
  - cnt: cycle counter.
  - X, Y: converted operand values, two's complement, sign bit plus n fractional bits.
  - W: residual, two's complement, 3 integer bits (incl. sign) plus F = n+δ fractional bits.
  - fsel: latched full_result_sel.
- All state resets to 0.
- In the cycle with cnt = c, the inputs are digit index k = c+1. Digits with k > n are forced to 0.
- Combinational datapath for each cycle:
  - V = 2·W + (X·y_k + Y_new·x_k)·2^-δ, where Y_new = Y + y_k·2^-k.
  - v̂ = V truncated toward −∞ to 2 fractional bits.
  - If c < δ: p = 0.
  - Otherwise: p = +1 if v̂ ≥ 1/2; p = −1 if v̂ < −1/2; p = 0 otherwise.
- Outputs: z = p, neg_z = −p, z_valid = (c ≥ δ). z is product digit c+1−δ.
- On each rising edge:
  - X += x_k·2^-k; Y = Y_new; W = V − p; cnt++.
  - If c = 0, fsel ← full_result_sel.
- Last cycle: c = δ+N−1, with N = n if fsel = 0 and N = 2n if fsel = 1. In the last cycle, fsel is the value latched at c = 0.
  - The last edge clears cnt, X, Y, W and fsel.
  - The next operation starts in the following cycle (back-to-back operation, no idle gap).
- The selection guarantees |W| < 2, so no overflow can occur. Arithmetic is exact: Σ z_i·2^-i = x·y when N = 2n, and is within 2^-n of x·y when N = n.
- clear = 1 on any edge forces all state to 0, regardless of cnt. It takes priority over the update.

## Timing
- z is combinational from x, y and the registered state (zero-latency path).
- The first product digit appears in the same cycle as input digit δ+1.
- Operation length is δ+n cycles (fsel = 0) or δ+2n cycles (fsel = 1).
- Asserting reset asynchronously zeroes all state. Consequently z = 00, neg_z = 00 and z_valid = 0 while reset is low.
- After release, the first edge consumes digit 1.
- reset or clear mid-operation discards the partial result with no output. The following cycle is cnt = 0.
- full_result_sel changes after c = 0 have no effect.

## Structure
- Shared package holds:
  - Digit codes DIG_POS = 2'b01, DIG_ZERO = 2'b00, DIG_NEG = 2'b11.
  - localparam RADIX_BITS = 2.
  - Digit-to-integer and negate functions.
- One sub-module, otf_converter, instantiated twice (X and Y):
  - Classical Q/QM on-the-fly conversion, so no carry propagation is needed.
  - Inputs: digit, k, clk, reset, clear.
  - Outputs: Q, and Q_next (the value including the current digit).
- Negation, selection and the residual update are inline logic in radix2_calc_vj.

## Test plan
- Reset, then x = y = 0 for 7 cycles with fsel = 0:
  - z = 0 throughout.
  - z_valid is 0 for cycles 1–3 and 1 for cycles 4–7.
  - cnt wraps to 0 after cycle 7.
- x = y = digits (1,0,0,0) = 1/2, fsel = 1:
  - Valid digits are (1,−1,0,0,0,0,0,0), value 1/4.
  - Residual W after cycle 4 is −1/2.
- x = (1,1,1,1), y = (1,0,0,0):
  - fsel = 0 gives digits (1,0,0,0).
  - fsel = 1 gives (1,0,0,0,−1,0,0,0), i.e. 15/32.
- x = (−1,0,0,0), y = (1,0,0,0), fsel = 0:
  - V at cycle 4 is −1/2, so p = 0 there.
  - Digits are (0,−1,0,0), i.e. −1/4.
  - neg_z mirrors z digit by digit.
- Two back-to-back operations, 1/2·1/2 then (1,1,1,1)·(1,0,0,0), fsel = 0:
  - The second result matches its standalone result.
  - No gap cycles between the operations.
- Assert clear at cnt = 4 during 1/2·1/2, then start (1,1,1,1)·(1,0,0,0):
  - The result is (1,0,0,0).
- Repeat the previous scenario with an asynchronous reset pulse instead of clear:
  - Outputs go to 0 immediately when reset asserts.
  - The result is (1,0,0,0).
